// File: rtl/diad_imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding,
// byte-count helper and checksum seed.
package diad_imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam int DEF_DATA_W = 24;
    localparam int DEF_ADDR_W = 24;

    localparam logic [7:0] CSUM_SEED = 8'h00;

    function automatic int bytes_for(input int bits);
        return (bits + 7) / 8;
    endfunction

    localparam int BPW       = bytes_for(DEF_DATA_W);
    localparam int LEN_BYTES = bytes_for(DEF_ADDR_W);

endpackage

// File: rtl/diad_imem_loader_pack.sv
// Little-endian byte-to-word packer; word_o/last_o are combinational views of
// the word as it would look once the byte on byte_i is accepted.
module diad_imem_loader_pack #(
    parameter int NB    = 3,
    parameter int CNT_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic [7:0]        byte_i,
    input  logic [CNT_W-1:0]  nbytes_i,
    output logic [NB*8-1:0]   word_o,
    output logic              last_o
);

    logic [NB*8-1:0]  word_q;
    logic [CNT_W-1:0] cnt_q;

    // First byte of a word starts from zero so short words carry no stale bytes.
    always_comb begin
        word_o = (cnt_q == '0) ? '0 : word_q;
        for (int i = 0; i < NB; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                word_o[i*8 +: 8] = byte_i;
            end
        end
    end

    assign last_o = en_i && (cnt_q == nbytes_i - 1'b1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (clear_i) begin
            cnt_q  <= '0;
        end else if (en_i) begin
            word_q <= word_o;
            cnt_q  <= last_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/diad_imem_loader.sv
// Boot-time imem loader: length header, packed payload words, optional XOR
// checksum (DIAD_IMEM_LOADER_CSUM_EN). Holds the core in reset until success.
module diad_imem_loader
    import diad_imem_loader_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 24
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_start,
    input  logic              iw_byte_valid,
    input  logic [7:0]        iw_byte_data,
    output logic              ow_byte_ready,
    output logic              or_mem_we,
    output logic [ADDR_W-1:0] or_mem_addr,
    output logic [DATA_W-1:0] or_mem_wdata,
    output logic              or_cpu_rst,
    output logic              or_busy,
    output logic              or_done,
    output logic              or_err,
    output logic [ADDR_W-1:0] or_words,
    output logic [2:0]        or_dbg_state
);

    localparam int WBYTES = bytes_for(DATA_W);
    localparam int HBYTES = bytes_for(ADDR_W);
    localparam int PACK_B = (WBYTES > HBYTES) ? WBYTES : HBYTES;
    localparam int CNT_W  = $clog2(PACK_B + 1);

`ifdef DIAD_IMEM_LOADER_CSUM_EN
    localparam state_t PAYLOAD_END = S_CSUM;
`else
    localparam state_t PAYLOAD_END = S_DONE;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [ADDR_W-1:0] words_q, words_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
`ifdef DIAD_IMEM_LOADER_CSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              byte_fire;
    logic              pack_en;
    logic              pack_clr;
    logic              pack_last;
    logic [CNT_W-1:0]  pack_nbytes;
    logic [PACK_B*8-1:0] pack_word;

    // Valid/ready: a byte moves on a clock edge where both are high; ready
    // depends only on the FSM state, never on valid.
    assign ow_byte_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign byte_fire     = iw_byte_valid && ow_byte_ready;
    assign pack_en       = byte_fire && ((state_q == S_LEN) || (state_q == S_DATA));
    assign pack_nbytes   = (state_q == S_LEN) ? CNT_W'(HBYTES) : CNT_W'(WBYTES);

    diad_imem_loader_pack #(
        .NB    (PACK_B),
        .CNT_W (CNT_W)
    ) u_pack (
        .clk_i    (iw_clk),
        .rst_i    (iw_rst),
        .clear_i  (pack_clr),
        .en_i     (pack_en),
        .byte_i   (iw_byte_data),
        .nbytes_i (pack_nbytes),
        .word_o   (pack_word),
        .last_o   (pack_last)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        widx_d   = widx_q;
        words_d  = we_q ? words_q + ADDR_W'(1) : words_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        pack_clr = 1'b0;
`ifdef DIAD_IMEM_LOADER_CSUM_EN
        csum_d   = pack_en ? (csum_q ^ iw_byte_data) : csum_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (iw_start) begin
                    state_d  = S_LEN;
                    len_d    = '0;
                    widx_d   = '0;
                    words_d  = '0;
                    pack_clr = 1'b1;
`ifdef DIAD_IMEM_LOADER_CSUM_EN
                    csum_d   = CSUM_SEED;
`endif
                end
            end
            S_LEN: begin
                if (pack_last) begin
                    len_d   = pack_word[ADDR_W-1:0];
                    state_d = (pack_word[ADDR_W-1:0] == '0) ? PAYLOAD_END : S_DATA;
                end
            end
            // widx counts words accepted; or_words lags it by the write cycle.
            S_DATA: begin
                if (pack_last) begin
                    we_d    = 1'b1;
                    addr_d  = widx_q;
                    wdata_d = pack_word[DATA_W-1:0];
                    widx_d  = widx_q + ADDR_W'(1);
                    if (widx_d == len_q) begin
                        state_d = PAYLOAD_END;
                    end
                end
            end
`ifdef DIAD_IMEM_LOADER_CSUM_EN
            S_CSUM: begin
                if (byte_fire) begin
                    state_d = (iw_byte_data == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            widx_q  <= '0;
            words_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef DIAD_IMEM_LOADER_CSUM_EN
            csum_q  <= CSUM_SEED;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            widx_q  <= widx_d;
            words_q <= words_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef DIAD_IMEM_LOADER_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign or_mem_we    = we_q;
    assign or_mem_addr  = addr_q;
    assign or_mem_wdata = wdata_q;
    assign or_words     = words_q;
    assign or_busy      = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign or_done      = (state_q == S_DONE);
    assign or_cpu_rst   = (state_q != S_DONE);
    assign or_dbg_state = state_q;
`ifdef DIAD_IMEM_LOADER_CSUM_EN
    assign or_err       = (state_q == S_ERR);
`else
    assign or_err       = 1'b0;
`endif

endmodule
